// File: rtl/mul_tag_aligner.sv
// mul_tag_aligner: issues operand pairs to the fp32 multiplier and re-attaches row/last tags to its results
module mul_tag_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_W      = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_a,
    input  logic [DATA_WIDTH-1:0] s_b,
    input  logic [ROW_W-1:0]      s_row,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    output logic                  mul_in_valid,
    input  logic                  mul_in_ready,
    input  logic                  mul_out_valid,
    output logic                  mul_out_ready,
    input  logic [DATA_WIDTH-1:0] mul_c,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ROW_W-1:0]      m_row,
    output logic                  m_last,
    output logic [CNT_W-1:0]      outstanding,
    output logic [15:0]           rows_done,
    output logic                  err_orphan
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ROW_W:0]   tags [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop;

    // Handshake gating from the registered occupancy only, so neither side sees a bypass path
    always_comb begin
        full          = outstanding == CNT_W'(DEPTH);
        empty         = outstanding == '0;
        mul_in_valid  = s_valid & ~full;
        s_ready       = mul_in_ready & ~full;
        m_valid       = mul_out_valid & ~empty;
        mul_out_ready = m_ready & ~empty;
        push          = s_valid & s_ready;
        pop           = m_valid & m_ready;
        mul_a         = s_a;
        mul_b         = s_b;
        m_data        = mul_c;
        {m_row, m_last} = tags[rd_ptr];
    end

    // Tag storage: capture row/last at the moment the pair is issued
    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= {s_row, s_last};
    end

    // Pointers, in-flight count, delivered-row counter and sticky orphan flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            rows_done   <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push != pop) outstanding <= push ? outstanding + CNT_W'(1) : outstanding - CNT_W'(1);
            if (pop && m_last) rows_done <= rows_done + 16'd1;
            if (mul_out_valid && empty) err_orphan <= 1'b1;
        end
    end
endmodule

// File: doc/mul_tag_aligner.md
# mul_tag_aligner

Issue/collect shim around the fp32 multiplier in the SpMV kernel.
- Accepts operand pairs carrying row metadata and issues them to the multiplier's a/b handshake.
- Holds the metadata in a tag FIFO while the product is in flight, then re-attaches it to the multiplier's result stream.
- Sits between the nonzero/vector-pairing stage and the row accumulator, so the downstream sees product, row and last together.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/product width
- ROW_W, 16, row-index tag width
- DEPTH, 16, tag FIFO entries = max products in flight; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of outstanding counter

Ports:
- clk  in  1  sole clock, all logic rising-edge
- rstn  in  1  reset, synchronous, active-low
- s_valid  in  1  upstream pair valid
- s_ready  out  1  upstream pair accepted when s_valid & s_ready
- s_a  in  DATA_WIDTH  matrix value
- s_b  in  DATA_WIDTH  vector value
- s_row  in  ROW_W  row index
- s_last  in  1  last nonzero of row
- mul_a  out  DATA_WIDTH  multiplier operand a (= s_a)
- mul_b  out  DATA_WIDTH  multiplier operand b (= s_b)
- mul_in_valid  out  1  multiplier input valid
- mul_in_ready  in  1  multiplier input ready (a_ready & b_ready)
- mul_out_valid  in  1  multiplier result valid
- mul_out_ready  out  1  multiplier result ready
- mul_c  in  DATA_WIDTH  multiplier result
- m_valid  out  1  downstream product valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  product (= mul_c)
- m_row  out  ROW_W  row tag of product
- m_last  out  1  last tag of product
- outstanding  out  CNT_W  products issued, not yet delivered
- rows_done  out  16  count of delivered products with last=1, wraps
- err_orphan  out  1  sticky: result arrived with no tag

## Operation
- Tag FIFO: register array DEPTH×(ROW_W+1), wr_ptr/rd_ptr log2(DEPTH) bits, wrap modulo DEPTH; count = outstanding.
- full = (count==DEPTH), empty = (count==0), both from registered count; no bypass.
- Issue side (combinational): mul_in_valid = s_valid & ~full; s_ready = mul_in_ready & ~full. s_ready must not depend on s_valid.
- push = s_valid & s_ready: write {s_row,s_last} at wr_ptr, wr_ptr+1.
- Collect side (combinational): m_valid = mul_out_valid & ~empty; mul_out_ready = m_ready & ~empty.
- m_data = mul_c; {m_row,m_last} = entry at rd_ptr.
- pop = m_valid & m_ready: rd_ptr+1; if m_last, rows_done+1 (wraps 0xFFFF→0).
- Count update: push&~pop +1; pop&~push −1; both or neither unchanged.
- At full, push is blocked even if pop occurs in the same cycle.
- Order: multiplier is in-order, so FIFO order equals result order.
- Orphan: mul_out_valid & empty sets err_orphan next edge. mul_out_ready stays 0 and m_valid stays 0 (multiplier stalls). Cleared only by reset.

## Timing
- Reset (rstn=0 at edge): count, pointers, rows_done, err_orphan ← 0.
- During and after reset: m_valid=0, mul_out_ready=0, outstanding=0; s_ready = mul_in_ready.
- Added latency: zero cycles on both paths (pure combinational pass-through plus tag read). End-to-end latency = multiplier latency.
- Throughput: one push and one pop per cycle sustained when not full/empty.
- A result never precedes its own push: multiplier latency ≥1, tag written at the push edge.
- Reset mid-operation: all tags discarded. The multiplier must be reset in the same cycles. Any result arriving afterwards is an orphan.

## Test plan
- Reset: hold rstn=0 2 cycles with mul_in_ready=1 → m_valid=0, outstanding=0, err_orphan=0, s_ready=1, rows_done=0.
- Single product: bench multiplier model, latency 8. Push a=0x40000000, b=0x40400000, row=5, last=1 → 8 cycles later m_valid=1, m_data=0x40C00000, m_row=5, m_last=1. outstanding goes 1→0 on pop; rows_done=1.
- Fill: DEPTH=16, m_ready=0, offer 20 pairs rows 0..19 → exactly 16 accepted, s_ready=0, outstanding=16. Raise m_ready → rows 0..19 delivered in order, final outstanding=0.
- Simultaneous push/pop: at outstanding=8, push and pop in same cycle → outstanding stays 8. At outstanding=16 with pop → no push that cycle, next cycle 15→push allowed.
- Random: random valid/ready on all three handshakes, 10000 pairs, random rows and last. Scoreboard row/last/product match in order; pointers wrap ≥600 times; rows_done equals count of last=1 mod 2^16.
- Orphan: with outstanding=0, model asserts mul_out_valid → err_orphan=1 next cycle, m_valid=0, mul_out_ready=0. Flag stays 1 until rstn=0.
